// File: rtl/msb_pkg.sv
// Shared types and default geometry for the multi-stream line buffer.
// Widths here describe the default build; modules recompute from their own parameters.
package msb_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_WAYS       = 8;
  localparam int DEF_RD_ELEMS   = 2;
  localparam int DEF_CHANNELS   = 2;
  localparam int DEF_NSTRMS     = 32;
  localparam int DEF_L1_NCL     = 16;
  localparam int DEF_OQ_DEPTH   = 4;

  localparam int CH_W = $clog2(DEF_CHANNELS);
  localparam int ST_W = $clog2(DEF_NSTRMS / DEF_CHANNELS);
  localparam int CL_W = $clog2(DEF_L1_NCL);
  localparam int OF_W = $clog2(DEF_WAYS);
  localparam int LAW  = ST_W + CL_W;
  localparam int LI_W = CH_W + LAW;

  typedef logic [LI_W-1:0] line_idx_t;

  typedef struct packed {
    logic                                  err;
    logic [DEF_RD_ELEMS*DEF_DATA_WIDTH-1:0] data;
  } rsp_t;

  function automatic line_idx_t line_idx(
    logic [CH_W-1:0] ch,
    logic [ST_W-1:0] st,
    logic [CL_W-1:0] cl
  );
    return {ch, st, cl};
  endfunction

endpackage

// File: rtl/msb_if.sv
// Read request/response handshake plus per-channel write and invalidate ports.
// master = requester/writer, slave = line buffer.
interface msb_if import msb_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WAYS       = DEF_WAYS,
  parameter int RD_ELEMS   = DEF_RD_ELEMS,
  parameter int channels   = DEF_CHANNELS,
  parameter int nstrms     = DEF_NSTRMS,
  parameter int l1_ncl     = DEF_L1_NCL
) ();

  localparam int CHW = $clog2(channels);
  localparam int STW = $clog2(nstrms / channels);
  localparam int CLW = $clog2(l1_ncl);
  localparam int OFW = $clog2(WAYS);
  localparam int AW  = STW + CLW;

  logic                             i_v;
  logic                             i_r;
  logic [CHW-1:0]                   i_ra_ch;
  logic [STW-1:0]                   i_ra_st;
  logic [CLW-1:0]                   i_ra_cl;
  logic [OFW-1:0]                   i_ra_of;
  logic                             o_v;
  logic                             o_r;
  logic [RD_ELEMS*DATA_WIDTH-1:0]   o_rd;
  logic                             o_err;
  logic [channels-1:0]              i_we;
  logic [channels*AW-1:0]           i_wa;
  logic [channels*WAYS*DATA_WIDTH-1:0] i_wd;
  logic [channels-1:0]              i_inv;
  logic [channels*AW-1:0]           i_inv_a;

  modport master (
    output i_v, i_ra_ch, i_ra_st, i_ra_cl, i_ra_of, o_r,
    output i_we, i_wa, i_wd, i_inv, i_inv_a,
    input  i_r, o_v, o_rd, o_err
  );

  modport slave (
    input  i_v, i_ra_ch, i_ra_st, i_ra_cl, i_ra_of, o_r,
    input  i_we, i_wa, i_wd, i_inv, i_inv_a,
    output i_r, o_v, o_rd, o_err
  );

endinterface

// File: rtl/msb_line_buffer_fifo.sv
// Synchronous FIFO with async reset; count is exported for credit flow control.
// A push into a full FIFO is taken only when a pop happens on the same edge.
module msb_out_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/msb_line_buffer.sv
// Multi-stream line buffer: per-channel line writes, valid bits, 2-stage read
// pipeline into a credit-controlled response queue.
module msb_line_buffer import msb_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WAYS       = DEF_WAYS,
  parameter int RD_ELEMS   = DEF_RD_ELEMS,
  parameter int channels   = DEF_CHANNELS,
  parameter int nstrms     = DEF_NSTRMS,
  parameter int l1_ncl     = DEF_L1_NCL,
  parameter int OQ_DEPTH   = DEF_OQ_DEPTH
) (
  input logic  clk1x,
  input logic  reset,
  msb_if.slave bus
);

  localparam int CHW  = $clog2(channels);
  localparam int STW  = $clog2(nstrms / channels);
  localparam int CLW  = $clog2(l1_ncl);
  localparam int OFW  = $clog2(WAYS);
  localparam int AW   = STW + CLW;
  localparam int LIW  = CHW + AW;
  localparam int NL   = 2 ** LIW;
  localparam int LW   = WAYS * DATA_WIDTH;
  localparam int RW   = RD_ELEMS * DATA_WIDTH;
  localparam int CNTW = $clog2(OQ_DEPTH + 1);

  typedef logic [WAYS-1:0][DATA_WIDTH-1:0] line_t;

  if (nstrms % channels != 0) begin : g_chk_st
    $error("nstrms must be a multiple of channels");
  end
  if (WAYS % RD_ELEMS != 0) begin : g_chk_rd
    $error("WAYS must be a multiple of RD_ELEMS");
  end

  line_t          mem [NL];
  logic [NL-1:0]  vld;

  logic           acc;
  logic [LIW-1:0] ridx;
  logic [OFW-1:0] aoff;
  line_t          rline;
  logic           rvld;

  logic           s1_v;
  logic           s1_ok;
  line_t          s1_line;
  logic [OFW-1:0] s1_of;
  logic           s2_v;
  logic [RW:0]    s2_rsp;

  logic [CNTW-1:0] cnt;
  logic [RW:0]     q_rsp;
  logic            q_v;
  logic            pop;

  assign ridx    = {bus.i_ra_ch, bus.i_ra_st, bus.i_ra_cl};
  assign aoff    = bus.i_ra_of & ~OFW'(RD_ELEMS - 1);
  assign bus.i_r = !reset &&
    (int'(cnt) + int'(s1_v) + int'(s2_v) < OQ_DEPTH);
  assign acc     = bus.i_v && bus.i_r;

  // Same-edge writes/invalidates are forwarded into the captured line
  always_comb begin
    rline = mem[ridx];
    rvld  = vld[ridx];
    for (int c = 0; c < channels; c++) begin
      if (bus.i_inv[c] &&
          {CHW'(c), bus.i_inv_a[c*AW +: AW]} == ridx)
        rvld = 1'b0;
    end
    for (int c = 0; c < channels; c++) begin
      if (bus.i_we[c] &&
          {CHW'(c), bus.i_wa[c*AW +: AW]} == ridx) begin
        rline = bus.i_wd[c*LW +: LW];
        rvld  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1x) begin
    for (int c = 0; c < channels; c++) begin
      if (bus.i_we[c])
        mem[{CHW'(c), bus.i_wa[c*AW +: AW]}] <= bus.i_wd[c*LW +: LW];
    end
  end

  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else begin
      for (int c = 0; c < channels; c++) begin
        if (bus.i_inv[c])
          vld[{CHW'(c), bus.i_inv_a[c*AW +: AW]}] <= 1'b0;
      end
      for (int c = 0; c < channels; c++) begin
        if (bus.i_we[c])
          vld[{CHW'(c), bus.i_wa[c*AW +: AW]}] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk1x or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= acc;
      s2_v <= s1_v;
    end
  end

  always_ff @(posedge clk1x) begin
    if (acc) begin
      s1_ok   <= rvld;
      s1_line <= rline;
      s1_of   <= aoff;
    end
    if (s1_v) begin
      s2_rsp <= s1_ok ? {1'b0, s1_line[s1_of +: RD_ELEMS]}
                      : {1'b1, RW'(0)};
    end
  end

  msb_out_fifo #(
    .WIDTH (RW + 1),
    .DEPTH (OQ_DEPTH)
  ) u_oq (
    .clk   (clk1x),
    .rst   (reset),
    .push  (s2_v),
    .din   (s2_rsp),
    .pop   (pop),
    .dout  (q_rsp),
    .valid (q_v),
    .count (cnt)
  );

  assign pop       = q_v && bus.o_r;
  assign bus.o_v   = q_v;
  assign bus.o_err = q_v && q_rsp[RW];
  assign bus.o_rd  = q_v ? q_rsp[RW-1:0] : '0;

endmodule

// File: tb/tb_msb_line_buffer.sv
// Randomised and directed bench for msb_line_buffer against an
// element-array reference model with an expected-response queue.
module tb_msb_line_buffer;

  localparam int DW  = 64;
  localparam int W   = 8;
  localparam int RE  = 2;
  localparam int LAW = 8;
  localparam int LW  = W * DW;

  logic clk = 1'b0;
  logic reset = 1'b1;

  msb_if bus ();

  msb_line_buffer dut (
    .clk1x (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]   mmem [512][W];
  logic            mvld [512];
  logic [RE*DW:0]  expq [$];
  logic [RE*DW:0]  last_rsp;
  logic            last_acc;
  int              n_chk = 0;
  int              n_fail = 0;
  int              n_pop = 0;

  function automatic logic [LW-1:0] mk_line(logic [63:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < W; k++) l[k*DW +: DW] = base + 64'(k);
    return l;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic idle();
    bus.i_v = 1'b0;
    bus.i_we = '0;
    bus.i_inv = '0;
  endtask

  task automatic set_wr(int c, int st, int cl, logic [LW-1:0] d);
    bus.i_we[c] = 1'b1;
    bus.i_wa[c*LAW +: LAW] = 8'(st * 16 + cl);
    bus.i_wd[c*LW +: LW] = d;
  endtask

  task automatic set_inv(int c, int st, int cl);
    bus.i_inv[c] = 1'b1;
    bus.i_inv_a[c*LAW +: LAW] = 8'(st * 16 + cl);
  endtask

  task automatic set_rd(int ch, int st, int cl, int of);
    bus.i_v = 1'b1;
    bus.i_ra_ch = 1'(ch);
    bus.i_ra_st = 4'(st);
    bus.i_ra_cl = 4'(cl);
    bus.i_ra_of = 3'(of);
  endtask

  // Called at a falling edge with inputs driven; models the next rising edge
  task automatic tick();
    logic [RE*DW:0] e;
    int idx;
    int rid;
    int ao;
    #2;
    last_acc = 1'b0;
    if (bus.o_v && bus.o_r) begin
      n_chk++;
      n_pop++;
      last_rsp = {bus.o_err, bus.o_rd};
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL rsp: got unexpected %h, required none", last_rsp);
      end else begin
        e = expq.pop_front();
        if (last_rsp !== e) begin
          n_fail++;
          $display("FAIL rsp: got %h, required %h", last_rsp, e);
        end
      end
    end
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        if (bus.i_inv[c]) begin
          idx = c * 256 + int'(bus.i_inv_a[c*LAW +: LAW]);
          mvld[idx] = 1'b0;
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (bus.i_we[c]) begin
          idx = c * 256 + int'(bus.i_wa[c*LAW +: LAW]);
          mvld[idx] = 1'b1;
          for (int k = 0; k < W; k++)
            mmem[idx][k] = bus.i_wd[c*LW + k*DW +: DW];
        end
      end
      if (bus.i_v && bus.i_r) begin
        last_acc = 1'b1;
        rid = int'(bus.i_ra_ch) * 256 + int'(bus.i_ra_st) * 16 +
              int'(bus.i_ra_cl);
        ao = int'(bus.i_ra_of) - (int'(bus.i_ra_of) % RE);
        e = '0;
        if (!mvld[rid]) e[RE*DW] = 1'b1;
        else for (int k = 0; k < RE; k++) e[k*DW +: DW] = mmem[rid][ao+k];
        expq.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    idle();
    bus.o_r = 1'b1;
    while (expq.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0",
               expq.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (bus.o_v !== 1'b0) begin
      n_fail++; $display("FAIL rst_ov: got %b, required 0", bus.o_v);
    end
    n_chk++;
    if (bus.i_r !== 1'b0) begin
      n_fail++; $display("FAIL rst_ir: got %b, required 0", bus.i_r);
    end
    n_chk++;
    if ({bus.o_err, bus.o_rd} !== '0) begin
      n_fail++; $display("FAIL rst_ord: got %h, required 0",
                         {bus.o_err, bus.o_rd});
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus.i_r !== 1'b1) begin
      n_fail++; $display("FAIL rel_ir: got %b, required 1", bus.i_r);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    idle();
    bus.o_r = 1'b1;
    set_wr(0, 1, 4, mk_line(64'h10));
    tick();
    idle();
    set_rd(0, 1, 4, 3);
    tick();
    idle();
    n_chk++;
    if (bus.o_v !== 1'b0) begin
      n_fail++; $display("FAIL lat_n1: got o_v %b, required 0", bus.o_v);
    end
    tick();
    n_chk++;
    if (bus.o_v !== 1'b0) begin
      n_fail++; $display("FAIL lat_n2: got o_v %b, required 0", bus.o_v);
    end
    tick();
    n_chk++;
    if (bus.o_v !== 1'b1) begin
      n_fail++; $display("FAIL lat_n3: got o_v %b, required 1", bus.o_v);
    end
    n_chk++;
    if ({bus.o_err, bus.o_rd} !== {1'b0, 64'h13, 64'h12}) begin
      n_fail++; $display("FAIL basic_rd: got %h, required %h",
                         {bus.o_err, bus.o_rd}, {1'b0, 64'h13, 64'h12});
    end
    drain();
  endtask

  task automatic test_unwritten();
    idle();
    set_rd(1, 2, 8, 0);
    tick();
    drain();
    n_chk++;
    if (last_rsp !== {1'b1, 128'h0}) begin
      n_fail++; $display("FAIL unwr_err: got %h, required err only",
                         last_rsp);
    end
    set_wr(1, 2, 8, mk_line(64'h800));
    tick();
    idle();
    set_rd(1, 2, 8, 5);
    tick();
    drain();
    n_chk++;
    if (last_rsp !== {1'b0, 64'h805, 64'h804}) begin
      n_fail++; $display("FAIL unwr_fill: got %h, required %h", last_rsp,
                         {1'b0, 64'h805, 64'h804});
    end
  endtask

  task automatic test_wr_inv();
    idle();
    set_wr(0, 0, 0, mk_line(64'hA0));
    set_inv(0, 0, 0);
    tick();
    idle();
    set_rd(0, 0, 0, 4);
    tick();
    drain();
    n_chk++;
    if (last_rsp !== {1'b0, 64'hA5, 64'hA4}) begin
      n_fail++; $display("FAIL wr_wins: got %h, required %h", last_rsp,
                         {1'b0, 64'hA5, 64'hA4});
    end
    set_inv(0, 0, 0);
    tick();
    idle();
    set_rd(0, 0, 0, 4);
    tick();
    drain();
    n_chk++;
    if (last_rsp !== {1'b1, 128'h0}) begin
      n_fail++; $display("FAIL inv_err: got %h, required err only",
                         last_rsp);
    end
  endtask

  task automatic test_back_to_back();
    int acc_n;
    int p0;
    idle();
    set_wr(0, 3, 1, mk_line(64'h100));
    set_wr(1, 5, 2, mk_line(64'h200));
    tick();
    idle();
    bus.o_r = 1'b0;
    acc_n = 0;
    p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      if (acc_n % 2 == 0) set_rd(0, 3, 1, acc_n % 8);
      else set_rd(1, 5, 2, acc_n % 8);
      tick();
      if (last_acc) acc_n++;
    end
    n_chk++;
    if (acc_n !== 4) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d, required 4", acc_n);
    end
    n_chk++;
    if (bus.i_r !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ir: got %b, required 0", bus.i_r);
    end
    bus.o_r = 1'b1;
    for (int i = 0; i < 40 && acc_n < 10; i++) begin
      if (acc_n % 2 == 0) set_rd(0, 3, 1, acc_n % 8);
      else set_rd(1, 5, 2, acc_n % 8);
      tick();
      if (last_acc) acc_n++;
    end
    drain();
    n_chk++;
    if (n_pop - p0 !== 10) begin
      n_fail++; $display("FAIL b2b_count: got %0d, required 10",
                         n_pop - p0);
    end
  endtask

  task automatic test_hazard();
    idle();
    set_wr(0, 9, 3, mk_line(64'h500));
    tick();
    idle();
    set_rd(0, 9, 3, 6);
    tick();
    idle();
    set_wr(0, 9, 3, mk_line(64'h600));
    tick();
    drain();
    n_chk++;
    if (last_rsp !== {1'b0, 64'h507, 64'h506}) begin
      n_fail++; $display("FAIL rbw_old: got %h, required %h", last_rsp,
                         {1'b0, 64'h507, 64'h506});
    end
    set_wr(0, 9, 3, mk_line(64'h700));
    set_rd(0, 9, 3, 1);
    tick();
    drain();
    n_chk++;
    if (last_rsp !== {1'b0, 64'h701, 64'h700}) begin
      n_fail++; $display("FAIL same_edge: got %h, required %h", last_rsp,
                         {1'b0, 64'h701, 64'h700});
    end
  endtask

  task automatic test_reset_mid();
    idle();
    set_wr(0, 7, 7, mk_line(64'h900));
    tick();
    idle();
    bus.o_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rd(0, 7, 7, 2 * i);
      tick();
    end
    idle();
    tick();
    tick();
    n_chk++;
    if (bus.o_v !== 1'b1) begin
      n_fail++; $display("FAIL mid_queued: got o_v %b, required 1", bus.o_v);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({bus.o_v, bus.i_r, bus.o_err} !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst: got v/r/err %b, required 000",
                         {bus.o_v, bus.i_r, bus.o_err});
    end
    n_chk++;
    if (bus.o_rd !== '0) begin
      n_fail++; $display("FAIL mid_rd: got %h, required 0", bus.o_rd);
    end
    expq.delete();
    for (int i = 0; i < 512; i++) mvld[i] = 1'b0;
    tick();
    reset = 1'b0;
    bus.o_r = 1'b1;
    set_rd(0, 7, 7, 0);
    tick();
    drain();
    n_chk++;
    if (last_rsp !== {1'b1, 128'h0}) begin
      n_fail++; $display("FAIL mid_inval: got %h, required err only",
                         last_rsp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle();
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 3) == 0)
          set_wr(c, $urandom_range(0, 1), $urandom_range(0, 3), rnd_line());
        if ($urandom_range(0, 5) == 0)
          set_inv(c, $urandom_range(0, 1), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1)
        set_rd($urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 7));
      bus.o_r = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mvld[i] = 1'b0;
    last_rsp = '0;
    last_acc = 1'b0;
    bus.i_ra_ch = '0;
    bus.i_ra_st = '0;
    bus.i_ra_cl = '0;
    bus.i_ra_of = '0;
    bus.i_wa = '0;
    bus.i_wd = '0;
    bus.i_inv_a = '0;
    bus.o_r = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_unwritten();
    test_wr_inv();
    test_back_to_back();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
